// File: rtl/nkmm_prog_loader.sv
// nkmm_prog_loader
//   Program memory for nkmm_cpu. Serves instruction fetches with one cycle of
//   registered latency. Also assembles a big-endian byte stream into 32-bit
//   words and writes them into the RAM, holding the CPU in reset while a load
//   is in progress.
//
// Ports
//   clk          single clock, everything on posedge
//   rst          synchronous reset, active low
//   prog_addr_i  CPU fetch word address (16 bit)
//   prog_data_o  registered instruction back to the CPU
//   cpu_rst_o    active-high reset to nkmm_cpu, high while loading
//   ld_start_i   begin (or restart) a load, single-cycle pulse
//   ld_byte_i    load data byte
//   ld_valid_i   load byte valid
//   ld_ready_o   loader accepts bytes (high for the whole of LOAD)
//   ld_done_i    end the load, single-cycle pulse
//   ld_count_o   words written by the current/last load
//   ld_err_o     sticky error flag for the current/last load
//   ld_csum_o    mod-256 sum of accepted bytes
//
// Configuration macro
//   NKMM_PROG_LOADER_CSUM_EN  when defined, ld_csum_o carries the running byte
//                             sum; otherwise it is tied to zero.

module nkmm_prog_loader #(
  parameter int                   ADDR_WIDTH = 8,
  parameter int                   INSN_WIDTH = 32,
  parameter logic [INSN_WIDTH-1:0] FILL_INSN = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           prog_addr_i,
  output logic [INSN_WIDTH-1:0] prog_data_o,
  output logic                  cpu_rst_o,
  input  logic                  ld_start_i,
  input  logic [7:0]            ld_byte_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic                  ld_done_i,
  output logic [ADDR_WIDTH:0]   ld_count_o,
  output logic                  ld_err_o,
  output logic [7:0]            ld_csum_o
);

  typedef enum logic {RUN, LOAD} state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Count value meaning "every RAM word has been written by this load".
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [INSN_WIDTH-1:0] mem [DEPTH];

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] wrAddr_q;
  logic [1:0]            phase_q;
  logic [INSN_WIDTH-9:0] shift_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  err_q;
  logic                  cpuRst_q;
  logic                  ready_q;
  logic [INSN_WIDTH-1:0] progData_q;

  logic                  accept;
  logic                  wordDone;
  logic                  isFull;
  logic                  memWe;
  logic [1:0]            phaseNext;
  logic                  addrHigh;

  // A byte is only taken in LOAD; a start pulse in the same cycle wins and the
  // byte is dropped, and reset suppresses any write in its cycle.
  assign accept    = rst && (state_q == LOAD) && ld_valid_i && !ld_start_i;
  assign wordDone  = accept && (phase_q == 2'd3);
  assign isFull    = (count_q == FULL_COUNT);
  assign memWe     = wordDone && !isFull;
  assign phaseNext = accept ? phase_q + 2'd1 : phase_q;
  assign addrHigh  = ((prog_addr_i >> ADDR_WIDTH) != 16'd0);

  // Instruction RAM write port. No reset: contents survive reset and loads.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[wrAddr_q] <= {shift_q, ld_byte_i};
    end
  end

  // Loader FSM, load counters and the registered fetch port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      wrAddr_q   <= '0;
      phase_q    <= '0;
      shift_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      cpuRst_q   <= 1'b1;
      ready_q    <= 1'b0;
      progData_q <= FILL_INSN;
    end else begin
      // Fetch sees the state before this edge, so the first cycle back in RUN
      // already returns RAM data.
      if (addrHigh || (state_q == LOAD)) begin
        progData_q <= FILL_INSN;
      end else begin
        progData_q <= mem[prog_addr_i[ADDR_WIDTH-1:0]];
      end

      if (ld_start_i) begin
        state_q  <= LOAD;
        wrAddr_q <= '0;
        phase_q  <= '0;
        shift_q  <= '0;
        count_q  <= '0;
        err_q    <= 1'b0;
        cpuRst_q <= 1'b1;
        ready_q  <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            cpuRst_q <= 1'b0;
            ready_q  <= 1'b0;
          end
          LOAD: begin
            if (accept) begin
              shift_q <= {shift_q[INSN_WIDTH-17:0], ld_byte_i};
              phase_q <= phaseNext;
              if (wordDone) begin
                if (isFull) begin
                  err_q <= 1'b1;
                end else begin
                  wrAddr_q <= wrAddr_q + 1'b1;
                  count_q  <= count_q + 1'b1;
                end
              end
            end
            // Done is evaluated after the same-cycle byte, so a word completed
            // here is kept and only a leftover partial word is an error.
            if (ld_done_i) begin
              state_q  <= RUN;
              cpuRst_q <= 1'b0;
              ready_q  <= 1'b0;
              phase_q  <= '0;
              if (phaseNext != 2'd0) begin
                err_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= RUN;
          end
        endcase
      end
    end
  end

`ifdef NKMM_PROG_LOADER_CSUM_EN
  logic [7:0] csum_q;

  // Running sum of every accepted byte, including dropped or partial words.
  always_ff @(posedge clk) begin
    if (!rst) begin
      csum_q <= '0;
    end else if (ld_start_i) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= csum_q + ld_byte_i;
    end
  end

  assign ld_csum_o = csum_q;
`else
  assign ld_csum_o = 8'h00;
`endif

  assign prog_data_o = progData_q;
  assign cpu_rst_o   = cpuRst_q;
  assign ld_ready_o  = ready_q;
  assign ld_count_o  = count_q;
  assign ld_err_o    = err_q;

endmodule

// File: tb/tb_nkmm_prog_loader.sv
// Testbench for nkmm_prog_loader. Loads programs through the byte port and
// checks load status outputs; fetch results go through a scoreboard queue,
// pushed when an address is driven and popped when the data comes back.

module tb_nkmm_prog_loader;

  localparam logic [31:0] FILL = 32'hF00DF00D;

  logic        clk;
  logic        rst;
  logic [15:0] prog_addr_i;
  logic [31:0] prog_data_o;
  logic        cpu_rst_o;
  logic        ld_start_i;
  logic [7:0]  ld_byte_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic        ld_done_i;
  logic [8:0]  ld_count_o;
  logic        ld_err_o;
  logic [7:0]  ld_csum_o;

  int errorCount = 0;
  int checkCount = 0;
  logic [31:0] expQ[$];

  nkmm_prog_loader #(
    .ADDR_WIDTH(8),
    .INSN_WIDTH(32),
    .FILL_INSN (FILL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_addr_i(prog_addr_i),
    .prog_data_o(prog_data_o),
    .cpu_rst_o  (cpu_rst_o),
    .ld_start_i (ld_start_i),
    .ld_byte_i  (ld_byte_i),
    .ld_valid_i (ld_valid_i),
    .ld_ready_o (ld_ready_o),
    .ld_done_i  (ld_done_i),
    .ld_count_o (ld_count_o),
    .ld_err_o   (ld_err_o),
    .ld_csum_o  (ld_csum_o)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expectation and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one load byte for a cycle, optionally with ld_done_i alongside.
  task automatic applyStimulus(input logic [7:0] b, input logic done);
    ld_valid_i = 1'b1;
    ld_byte_i  = b;
    ld_done_i  = done;
    step();
    ld_valid_i = 1'b0;
    ld_done_i  = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) begin
      applyStimulus(w[k*8 +: 8], 1'b0);
    end
  endtask

  task automatic pulseStart();
    ld_start_i = 1'b1;
    step();
    ld_start_i = 1'b0;
  endtask

  task automatic pulseDone();
    ld_done_i = 1'b1;
    step();
    ld_done_i = 1'b0;
  endtask

  // Drive a fetch address and queue its expected data; the result is popped
  // once the registered read port has had its edge.
  task automatic applyFetch(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] want;
    prog_addr_i = addr;
    expQ.push_back(exp);
    step();
    want = expQ.pop_front();
    checkOutput(tag, prog_data_o, want);
  endtask

  initial begin
    rst         = 1'b0;
    prog_addr_i = 16'h0000;
    ld_start_i  = 1'b0;
    ld_byte_i   = 8'h00;
    ld_valid_i  = 1'b0;
    ld_done_i   = 1'b0;

    // Reset state.
    step();
    checkOutput("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    checkOutput("rst_ready", {31'd0, ld_ready_o}, 32'd0);
    checkOutput("rst_count", {23'd0, ld_count_o}, 32'd0);
    checkOutput("rst_err", {31'd0, ld_err_o}, 32'd0);
    checkOutput("rst_csum", {24'd0, ld_csum_o}, 32'd0);
    checkOutput("rst_data", prog_data_o, FILL);
    rst = 1'b1;
    step();
    checkOutput("run_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);

    // Basic two-word load.
    pulseStart();
    checkOutput("ld_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    checkOutput("ld_ready", {31'd0, ld_ready_o}, 32'd1);
    sendWord(32'h08010002);
    checkOutput("ld_count1", {23'd0, ld_count_o}, 32'd1);
    sendWord(32'h0c010003);
    applyFetch("fetch_in_load", 16'h0000, FILL);
    checkOutput("ld_cpu_rst_hold", {31'd0, cpu_rst_o}, 32'd1);
    pulseDone();
    checkOutput("done_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
    checkOutput("done_ready", {31'd0, ld_ready_o}, 32'd0);
    checkOutput("done_count2", {23'd0, ld_count_o}, 32'd2);
    checkOutput("done_err0", {31'd0, ld_err_o}, 32'd0);
    applyFetch("fetch_w0", 16'h0000, 32'h08010002);
    applyFetch("fetch_w1", 16'h0001, 32'h0c010003);
    applyFetch("fetch_oor", 16'h0100, FILL);

    // Bytes in RUN are ignored.
    applyStimulus(8'h77, 1'b0);
    checkOutput("run_byte_count", {23'd0, ld_count_o}, 32'd2);

    // Partial word at done.
    pulseStart();
    for (int k = 0; k < 6; k++) applyStimulus(8'(8'h11 * (k + 1)), 1'b0);
    pulseDone();
    checkOutput("part_count", {23'd0, ld_count_o}, 32'd1);
    checkOutput("part_err", {31'd0, ld_err_o}, 32'd1);
    applyFetch("part_w0", 16'h0000, 32'h11223344);
    applyFetch("part_w1", 16'h0001, 32'h0c010003);

    // Done together with the final byte of a word.
    pulseStart();
    applyStimulus(8'haa, 1'b0);
    applyStimulus(8'hbb, 1'b0);
    applyStimulus(8'hcc, 1'b0);
    applyStimulus(8'hdd, 1'b1);
    checkOutput("bd_count", {23'd0, ld_count_o}, 32'd1);
    checkOutput("bd_err", {31'd0, ld_err_o}, 32'd0);
    checkOutput("bd_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
    applyFetch("bd_w0", 16'h0000, 32'haabbccdd);

    // Start and done together mid-word: start wins and clears the phase.
    pulseStart();
    sendWord(32'h12345678);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    ld_start_i = 1'b1;
    ld_done_i  = 1'b1;
    step();
    ld_start_i = 1'b0;
    ld_done_i  = 1'b0;
    checkOutput("sd_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    checkOutput("sd_ready", {31'd0, ld_ready_o}, 32'd1);
    checkOutput("sd_count", {23'd0, ld_count_o}, 32'd0);
    pulseDone();
    checkOutput("sd_err", {31'd0, ld_err_o}, 32'd0);
    applyFetch("sd_w0", 16'h0000, 32'h12345678);

    // Checksum.
    pulseStart();
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'h02, 1'b0);
`ifdef NKMM_PROG_LOADER_CSUM_EN
    checkOutput("csum", {24'd0, ld_csum_o}, 32'h01);
`else
    checkOutput("csum", {24'd0, ld_csum_o}, 32'h00);
`endif
    pulseDone();
    checkOutput("csum_err", {31'd0, ld_err_o}, 32'd1);

    // Fill the whole RAM, then one extra word.
    pulseStart();
    for (int i = 0; i < 256; i++) sendWord(32'h5A000000 | 32'(i));
    checkOutput("full_count", {23'd0, ld_count_o}, 32'd256);
    checkOutput("full_err0", {31'd0, ld_err_o}, 32'd0);
    sendWord(32'h5A000100);
    checkOutput("over_count", {23'd0, ld_count_o}, 32'd256);
    checkOutput("over_err", {31'd0, ld_err_o}, 32'd1);
    pulseDone();
    applyFetch("over_w0", 16'h0000, 32'h5A000000);
    applyFetch("over_w255", 16'h00FF, 32'h5A0000FF);

    // Reset in the middle of a word.
    pulseStart();
    sendWord(32'h01020304);
    applyStimulus(8'h09, 1'b0);
    applyStimulus(8'h0a, 1'b0);
    rst = 1'b0;
    step();
    checkOutput("mid_rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    checkOutput("mid_rst_err", {31'd0, ld_err_o}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, ld_ready_o}, 32'd0);
    rst = 1'b1;
    step();
    checkOutput("mid_run_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
    applyFetch("mid_w0", 16'h0000, 32'h01020304);
    applyFetch("mid_w1", 16'h0001, 32'h5A000001);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
